nbit_nonrestoring_divider: RTL and testbench

//  Sequential unsigned N-bit divider using the non-restoring algorithm.
//  One nbit_add_sub instance, N+1 bits wide, adds or subtracts the divisor each iteration.

---
 rtl/nbit_nonrestoring_divider_pkg.sv | 16 +
 rtl/nbit_nonrestoring_divider_add_sub.sv | 13 +
 rtl/nbit_nonrestoring_divider.sv | 143 ++++++++++++++
 tb/tb_nbit_nonrestoring_divider.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nbit_nonrestoring_divider_pkg.sv
// Shared FSM encoding and sizing helper for the non-restoring divider.
package nbit_nonrestoring_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Width needed for a counter that is loaded with n and counts down to 1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nbit_nonrestoring_divider_add_sub.sv
// n-bit adder/subtractor: s = x - y when control_bit=1, else x + y (two's complement).
module nbit_add_sub #(
  parameter int n = 5
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         control_bit,
  output logic [n-1:0] s
);

  assign s = x + (y ^ {n{control_bit}}) + {{(n-1){1'b0}}, control_bit};

endmodule

// File: rtl/nbit_nonrestoring_divider.sv
// Sequential unsigned N-bit non-restoring divider with valid/ready on both sides.
module nbit_nonrestoring_divider
  import nbit_nonrestoring_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = cnt_width(N);

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [N:0]    a_q, a_d;
  logic        [N-1:0]  q_q, q_d;
  logic        [N:0]    m_q, m_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic        [N-1:0]  quotient_q, quotient_d;
  logic        [N-1:0]  remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;

  logic        [N:0]    addsub_x;
  logic        [N:0]    addsub_s;
  logic                 addsub_ctrl;
  logic signed [N:0]    a_fixed;

  // CALC feeds the shifted partial remainder; FIX feeds A itself with a forced add.
  always_comb begin
    addsub_x    = {a_q[N-1:0], q_q[N-1]};
    addsub_ctrl = ~a_q[N];
    if (state_q == S_FIX) begin
      addsub_x    = a_q;
      addsub_ctrl = 1'b0;
    end
  end

  nbit_add_sub #(.n(N + 1)) u_addsub (
    .x           (addsub_x),
    .y           (m_q),
    .control_bit (addsub_ctrl),
    .s           (addsub_s)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    a_fixed     = a_q[N] ? signed'(addsub_s) : a_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            a_d     = '0;
            q_d     = dividend;
            m_d     = {1'b0, divisor};
            cnt_d   = CNT_W'(N);
            state_d = S_CALC;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_CALC: begin
        a_d   = signed'(addsub_s);
        q_d   = {q_q[N-2:0], ~addsub_s[N]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        a_d         = a_fixed;
        quotient_d  = q_q;
        remainder_d = a_fixed[N-1:0];
        dbz_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nbit_nonrestoring_divider.sv
// Bench for nbit_nonrestoring_divider (N=4): directed vectors, reset abort, backpressure, full sweep.
module tb_nbit_nonrestoring_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int q;
    int r;
    int z;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  nbit_nonrestoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = (1 << N) - 1;
      e.r = a;
      e.z = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard bookkeeping on each active edge.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) sb.push_back(model(int'(dividend), int'(divisor)));
    if (!rst && out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
  end

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("cmp_quotient", int'(quotient), sb[0].q);
        chk("cmp_remainder", int'(remainder), sb[0].r);
        chk("cmp_div_by_zero", int'(div_by_zero), sb[0].z);
      end
    end
  end

  task automatic send(input int a, input int b);
    int guard = 0;
    dividend = N'(a);
    divisor  = N'(b);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 100) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
      if (lat > 50) begin
        chk("wait_valid_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input int a, input int b,
                          input int eq, input int er, input int ez, input int elat);
    int lat;
    send(a, b);
    wait_valid(lat);
    chk({name, "_latency"}, lat, elat);
    chk({name, "_q"}, int'(quotient), eq);
    chk({name, "_r"}, int'(remainder), er);
    chk({name, "_dbz"}, int'(div_by_zero), ez);
    consume();
  endtask

  initial begin
    int   lat;
    bit   done;
    int   guard;
    exp_t e;

    // Hand-computed values that pin the model itself.
    e = model(13, 3);  chk("model_13_3_q", e.q, 4);  chk("model_13_3_r", e.r, 1);
    e = model(7, 0);   chk("model_7_0_q", e.q, 15);  chk("model_7_0_z", e.z, 1);
    e = model(2, 9);   chk("model_2_9_r", e.r, 2);

    // Reset state
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-CALC abandons the operation
    send(13, 3);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk);
      #1 chk("midrst_no_result", int'(out_valid), 0);
    end
    directed("after_rst_13_3", 13, 3, 4, 1, 0, N + 1);

    directed("d13_3", 13, 3, 4, 1, 0, N + 1);
    directed("d15_1", 15, 1, 15, 0, 0, N + 1);
    directed("d2_9", 2, 9, 0, 2, 0, N + 1);
    directed("d7_0", 7, 0, 15, 7, 1, 1);

    // Backpressure: result held stable while out_ready stays low
    send(12, 5);
    wait_valid(lat);
    chk("bp_latency", lat, N + 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid_held", int'(out_valid), 1);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_q", int'(quotient), 2);
      chk("bp_r", int'(remainder), 2);
    end
    consume();
    chk("bp_released_out_valid", int'(out_valid), 0);
    chk("bp_released_in_ready", int'(in_ready), 1);

    // Exhaustive sweep, back-to-back, random out_ready
    done  = 1'b0;
    guard = 0;
    fork
      begin
        for (int a = 0; a < (1 << N); a++)
          for (int b = 0; b < (1 << N); b++)
            send(a, b);
        done = 1'b1;
      end
      begin
        while (!(done && sb.size() == 0) && guard < 20000) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
          guard++;
        end
        out_ready = 1'b0;
      end
    join
    chk("sweep_drained", sb.size(), 0);
    chk("sweep_within_budget", int'(guard < 20000), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
